lsu: RTL and testbench

//  Load/store unit directly downstream of exu: takes the ALU-computed address, rs2 store data and
//  the decoded memory op, runs a valid/ready transaction on the data-memory port, and returns the

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_mem_if.sv | 30 +++
 rtl/lsu_align.sv | 78 +++++++
 rtl/lsu.sv | 163 ++++++++++++++++
 tb/tb_lsu.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, memory
// op (funct3) encodings and the byte-enable width of the data-memory port.
package lsu_pkg;

  localparam int MEM_MASK_W = 4;

  // funct3 encodings; loads use all five, stores only B/H/W.
  localparam logic [2:0] LSU_LB  = 3'b000;
  localparam logic [2:0] LSU_LH  = 3'b001;
  localparam logic [2:0] LSU_LW  = 3'b010;
  localparam logic [2:0] LSU_LBU = 3'b100;
  localparam logic [2:0] LSU_LHU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_RESP = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_if.sv
// Data-memory port of the LSU: a valid/ready request channel plus a
// separate rvalid/rdata read-return channel.
//  master (LSU side) : drives valid, wen, addr, wdata, wmask
//  slave  (memory)   : drives ready, rvalid, rdata
interface lsu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import lsu_pkg::*;

  logic                  valid;
  logic                  ready;
  logic                  wen;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [MEM_MASK_W-1:0] wmask;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output valid, wen, addr, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, wen, addr, wdata, wmask,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU (32-bit data only).
//  funct3_i, wen_i, addr_lo_i : memory op, direction and byte offset
//  rs2_i                      : store data, LSB-justified
//  rword_i                    : raw read word from memory
//  wmask_o, wdata_o           : byte enables / lane-replicated store data (0 for loads)
//  err_o                      : illegal funct3 for the direction, or misaligned access
//  rdata_o                    : extracted, sign/zero-extended load data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]            funct3_i,
  input  logic                  wen_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [31:0]           rs2_i,
  input  logic [31:0]           rword_i,
  output logic [MEM_MASK_W-1:0] wmask_o,
  output logic [31:0]           wdata_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_sel = rword_i[7:0];
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      default: byte_sel = rword_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  always_comb begin
    wmask_o = '0;
    wdata_o = '0;
    err_o   = 1'b0;
    rdata_o = '0;
    case (funct3_i)
      LSU_LB: begin
        if (wen_i) begin
          wmask_o = 4'b0001 << addr_lo_i;
          wdata_o = {4{rs2_i[7:0]}};
        end
        rdata_o = {{24{byte_sel[7]}}, byte_sel};
      end
      LSU_LH: begin
        err_o = addr_lo_i[0];
        if (wen_i) begin
          wmask_o = 4'b0011 << addr_lo_i;
          wdata_o = {2{rs2_i[15:0]}};
        end
        rdata_o = {{16{half_sel[15]}}, half_sel};
      end
      LSU_LW: begin
        err_o = (addr_lo_i != 2'b00);
        if (wen_i) begin
          wmask_o = 4'b1111;
          wdata_o = rs2_i;
        end
        rdata_o = rword_i;
      end
      // Unsigned variants exist only for loads.
      LSU_LBU: begin
        err_o   = wen_i;
        rdata_o = {24'h0, byte_sel};
      end
      LSU_LHU: begin
        err_o   = wen_i | addr_lo_i[0];
        rdata_o = {16'h0, half_sel};
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts a memory op from the execute stage, performs one
// valid/ready transaction on the data-memory port and returns the aligned,
// extended load result with a one-cycle done pulse.
//  i_clk, i_rst_n         : clock, asynchronous active-low reset
//  i_lsu_valid/o_lsu_ready: request handshake (ready only while idle)
//  i_lsu_wen, i_lsu_funct3: direction and access size/signedness
//  i_exu_aluout           : byte address
//  i_idu_rs2_data         : store data
//  o_lsu_done/rdata/err   : completion pulse, load data, error flag
//  mem                    : data-memory port (master side)
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic              i_lsu_wen,
  input  logic [2:0]        i_lsu_funct3,
  input  logic [ADDR_W-1:0] i_exu_aluout,
  input  logic [DATA_W-1:0] i_idu_rs2_data,
  output logic              o_lsu_done,
  output logic [DATA_W-1:0] o_lsu_rdata,
  output logic              o_lsu_err,
  lsu_mem_if.master         mem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  // Abort on the last permitted REQ/WAIT cycle so exactly TIMEOUT_CYC cycles are spent waiting.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic                  in_idle;
  logic [2:0]            al_funct3;
  logic                  al_wen;
  logic [1:0]            al_addr_lo;
  logic [DATA_W-1:0]     al_rs2;
  logic [MEM_MASK_W-1:0] al_wmask;
  logic [DATA_W-1:0]     al_wdata;
  logic                  al_err;
  logic [DATA_W-1:0]     al_rdata;

  assign in_idle = (state_q == LSU_IDLE);

  // The aligner sees the live request while idle (to classify it at accept)
  // and the latched op afterwards, so later input changes have no effect.
  assign al_funct3  = in_idle ? i_lsu_funct3       : funct3_q;
  assign al_wen     = in_idle ? i_lsu_wen          : wen_q;
  assign al_addr_lo = in_idle ? i_exu_aluout[1:0]  : addr_q[1:0];
  assign al_rs2     = in_idle ? i_idu_rs2_data     : wdata_q;

  lsu_align u_align (
    .funct3_i  (al_funct3),
    .wen_i     (al_wen),
    .addr_lo_i (al_addr_lo),
    .rs2_i     (al_rs2),
    .rword_i   (mem.rdata),
    .wmask_o   (al_wmask),
    .wdata_o   (al_wdata),
    .err_o     (al_err),
    .rdata_o   (al_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      LSU_IDLE: begin
        if (i_lsu_valid) begin
          addr_d   = i_exu_aluout;
          wen_d    = i_lsu_wen;
          funct3_d = i_lsu_funct3;
          wdata_d  = i_idu_rs2_data;
          rdata_d  = '0;
          err_d    = al_err;
          cnt_d    = '0;
          // Bad ops skip the memory port entirely and report straight away.
          state_d  = al_err ? LSU_RESP : LSU_REQ;
        end
      end
      LSU_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.ready) begin
          if (wen_q) begin
            state_d = LSU_RESP;
          end else if (mem.rvalid) begin
            rdata_d = al_rdata;
            state_d = LSU_RESP;
          end else begin
            state_d = LSU_WAIT;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = LSU_RESP;
        end
      end
      LSU_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.rvalid) begin
          rdata_d = al_rdata;
          state_d = LSU_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = LSU_RESP;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= LSU_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      funct3_q <= 3'b000;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign o_lsu_ready = in_idle;
  assign o_lsu_done  = (state_q == LSU_RESP);
  assign o_lsu_rdata = o_lsu_done ? rdata_q : '0;
  assign o_lsu_err   = o_lsu_done & err_q;

  // Request fields are forced to zero whenever no request is outstanding.
  assign mem.valid = (state_q == LSU_REQ);
  assign mem.wen   = mem.valid & wen_q;
  assign mem.addr  = mem.valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem.wdata = mem.valid ? al_wdata : '0;
  assign mem.wmask = mem.valid ? al_wmask : '0;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 1023;

  logic        clk;
  logic        rst_n;
  logic        lsu_valid;
  logic        lsu_ready;
  logic        lsu_wen;
  logic [2:0]  lsu_funct3;
  logic [31:0] aluout;
  logic [31:0] rs2;
  logic        lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_err;

  lsu_mem_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_lsu_valid    (lsu_valid),
    .o_lsu_ready    (lsu_ready),
    .i_lsu_wen      (lsu_wen),
    .i_lsu_funct3   (lsu_funct3),
    .i_exu_aluout   (aluout),
    .i_idu_rs2_data (rs2),
    .o_lsu_done     (lsu_done),
    .o_lsu_rdata    (lsu_rdata),
    .o_lsu_err      (lsu_err),
    .mem            (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rword;
    int          rdly;   // cycles of REQ before mem ready
    int          rvdly;  // cycles from ready to rvalid (0 = same cycle)
    logic [3:0]  emask;
    logic [31:0] ewdata;
    logic [31:0] emaddr;
    logic [31:0] erdata;
    logic        eerr;
    int          elat;   // cycles from accept cycle to done cycle
    logic        emem;   // a memory request is expected
  } vec_t;

  vec_t vecs[14];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else passed++;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int  c;
    bit  seen;
    bit  fin;
    @(negedge clk);
    chk({nm, " ready_idle"}, 32'(lsu_ready), 32'd1);
    lsu_valid     = 1'b1;
    lsu_wen       = v.wen;
    lsu_funct3    = v.f3;
    aluout        = v.addr;
    rs2           = v.rs2;
    mem_if.rdata  = v.rword;
    @(negedge clk);
    // Scramble request inputs after accept; the op must already be latched.
    lsu_valid  = 1'b0;
    lsu_wen    = ~v.wen;
    lsu_funct3 = 3'b111;
    aluout     = ~v.addr;
    rs2        = ~v.rs2;
    seen = 1'b0;
    fin  = 1'b0;
    c    = 1;
    while (!fin && c <= 50) begin
      mem_if.ready  = (c == 1 + v.rdly);
      mem_if.rvalid = (v.rvdly == 0) ? (c == 1 + v.rdly) : (c == 1 + v.rdly + v.rvdly);
      if (mem_if.valid && !seen) begin
        seen = 1'b1;
        chk({nm, " maddr"}, mem_if.addr, v.emaddr);
        chk({nm, " mwen"}, 32'(mem_if.wen), 32'(v.wen));
        chk({nm, " wmask"}, 32'(mem_if.wmask), 32'(v.emask));
        if (v.wen) chk({nm, " wdata"}, mem_if.wdata, v.ewdata);
      end
      if (lsu_done) begin
        fin = 1'b1;
        chk({nm, " latency"}, 32'(c), 32'(v.elat));
        chk({nm, " rdata"}, lsu_rdata, v.erdata);
        chk({nm, " err"}, 32'(lsu_err), 32'(v.eerr));
        chk({nm, " ready_in_resp"}, 32'(lsu_ready), 32'd0);
        mem_if.ready  = 1'b0;
        mem_if.rvalid = 1'b0;
      end else begin
        @(negedge clk);
        c++;
      end
    end
    if (!fin) begin
      total++;
      $display("FAIL %s done_timeout: no done within 50 cycles", nm);
      mem_if.ready  = 1'b0;
      mem_if.rvalid = 1'b0;
    end
    chk({nm, " mem_req"}, 32'(seen), 32'(v.emem));
    @(negedge clk);
    chk({nm, " ready_after"}, 32'(lsu_ready), 32'd1);
    chk({nm, " done_after"}, 32'(lsu_done), 32'd0);
  endtask

  initial begin
    //          wen f3      addr          rs2           rword         rd rv mask     ewdata        emaddr        erdata        err lat mem
    vecs[0]  = '{1'b1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0,        0, 0, 4'b1111, 32'hDEADBEEF, 32'h80000004, 32'h0,        1'b0, 2, 1'b1};
    vecs[1]  = '{1'b1, 3'b000, 32'h80000003, 32'h000000A5, 32'h0,        1, 0, 4'b1000, 32'hA5A5A5A5, 32'h80000000, 32'h0,        1'b0, 3, 1'b1};
    vecs[2]  = '{1'b1, 3'b001, 32'h80000002, 32'h1234CAFE, 32'h0,        0, 0, 4'b1100, 32'hCAFECAFE, 32'h80000000, 32'h0,        1'b0, 2, 1'b1};
    vecs[3]  = '{1'b0, 3'b000, 32'h80000002, 32'h0,        32'h0080FF00, 0, 3, 4'b0000, 32'h0,        32'h80000000, 32'hFFFFFF80, 1'b0, 5, 1'b1};
    vecs[4]  = '{1'b0, 3'b100, 32'h80000002, 32'h0,        32'h0080FF00, 0, 3, 4'b0000, 32'h0,        32'h80000000, 32'h00000080, 1'b0, 5, 1'b1};
    vecs[5]  = '{1'b0, 3'b001, 32'h80000001, 32'h0,        32'hFFFFFFFF, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 32'h80000008, 32'h0,        32'h11223344, 0, 0, 4'b0000, 32'h0,        32'h80000008, 32'h11223344, 1'b0, 2, 1'b1};
    vecs[7]  = '{1'b0, 3'b001, 32'h80000006, 32'h0,        32'h80017FFF, 2, 0, 4'b0000, 32'h0,        32'h80000004, 32'hFFFF8001, 1'b0, 4, 1'b1};
    vecs[8]  = '{1'b0, 3'b101, 32'h80000006, 32'h0,        32'h80017FFF, 2, 0, 4'b0000, 32'h0,        32'h80000004, 32'h00008001, 1'b0, 4, 1'b1};
    vecs[9]  = '{1'b0, 3'b000, 32'h80000001, 32'h0,        32'h00007F00, 0, 1, 4'b0000, 32'h0,        32'h80000000, 32'h0000007F, 1'b0, 3, 1'b1};
    vecs[10] = '{1'b1, 3'b010, 32'h80000002, 32'h12345678, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1, 1'b0};
    vecs[11] = '{1'b0, 3'b011, 32'h80000000, 32'h0,        32'hFFFFFFFF, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1, 1'b0};
    vecs[12] = '{1'b1, 3'b100, 32'h80000000, 32'h000000FF, 32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        1'b1, 1, 1'b0};
    vecs[13] = '{1'b1, 3'b000, 32'h80000001, 32'hFFFFFF3C, 32'h0,        0, 0, 4'b0010, 32'h3C3C3C3C, 32'h80000000, 32'h0,        1'b0, 2, 1'b1};

    rst_n         = 1'b0;
    lsu_valid     = 1'b0;
    lsu_wen       = 1'b0;
    lsu_funct3    = 3'b000;
    aluout        = 32'h0;
    rs2           = 32'h0;
    mem_if.ready  = 1'b0;
    mem_if.rvalid = 1'b0;
    mem_if.rdata  = 32'h0;

    #1;
    chk("rst ready", 32'(lsu_ready), 32'd1);
    chk("rst done", 32'(lsu_done), 32'd0);
    chk("rst err", 32'(lsu_err), 32'd0);
    chk("rst rdata", lsu_rdata, 32'h0);
    chk("rst mvalid", 32'(mem_if.valid), 32'd0);
    chk("rst maddr", mem_if.addr, 32'h0);
    chk("rst wmask", 32'(mem_if.wmask), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Timeout: LW never acknowledged.
    @(negedge clk);
    lsu_valid    = 1'b1;
    lsu_wen      = 1'b0;
    lsu_funct3   = 3'b010;
    aluout       = 32'h80000020;
    mem_if.ready = 1'b0;
    @(negedge clk);
    lsu_valid = 1'b0;
    for (int c = 1; c <= TO + 1; c++) begin
      if (c == 1) chk("to mvalid_first", 32'(mem_if.valid), 32'd1);
      if (c == TO) begin
        chk("to mvalid_last", 32'(mem_if.valid), 32'd1);
        chk("to no_early_done", 32'(lsu_done), 32'd0);
      end
      if (c == TO + 1) begin
        chk("to done", 32'(lsu_done), 32'd1);
        chk("to err", 32'(lsu_err), 32'd1);
        chk("to rdata", lsu_rdata, 32'h0);
        chk("to mvalid_drop", 32'(mem_if.valid), 32'd0);
      end else begin
        @(negedge clk);
      end
    end
    // Late read return while idle must be ignored.
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'hFFFFFFFF;
    @(negedge clk);
    chk("late ready", 32'(lsu_ready), 32'd1);
    chk("late done", 32'(lsu_done), 32'd0);
    mem_if.rvalid = 1'b0;
    @(negedge clk);
    chk("late done2", 32'(lsu_done), 32'd0);
    chk("late mvalid", 32'(mem_if.valid), 32'd0);
    run_vec(vecs[6], "after_to");

    // Reset while in REQ: request must drop immediately.
    @(negedge clk);
    lsu_valid  = 1'b1;
    lsu_wen    = 1'b0;
    lsu_funct3 = 3'b010;
    aluout     = 32'h80000010;
    @(negedge clk);
    lsu_valid = 1'b0;
    chk("rreq mvalid_pre", 32'(mem_if.valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rreq mvalid", 32'(mem_if.valid), 32'd0);
    chk("rreq ready", 32'(lsu_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while in WAIT.
    @(negedge clk);
    lsu_valid  = 1'b1;
    lsu_funct3 = 3'b010;
    aluout     = 32'h80000010;
    @(negedge clk);
    lsu_valid    = 1'b0;
    mem_if.ready = 1'b1;
    @(negedge clk);
    mem_if.ready = 1'b0;
    chk("rwait ready_pre", 32'(lsu_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rwait mvalid", 32'(mem_if.valid), 32'd0);
    chk("rwait ready", 32'(lsu_ready), 32'd1);
    chk("rwait done", 32'(lsu_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[6], "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
